// File: rtl/xilinx_board_io_cond.sv
// xilinx_board_io_cond
// Board-I/O conditioning between raw board pins and the SoC pad ports:
// per-input synchroniser + debouncer with optional edge pulses, a global
// "debounce window elapsed" flag, and a synchronised, stretched,
// active-low SoC reset generated from the raw reset button.
// Optional feature macro: BOARD_IO_EDGE_DETECT_EN (define to build the
// rise_o/fall_o registers; otherwise both outputs are tied to 0).
module xilinx_board_io_cond #(
    parameter int N_IN                = 8,
    parameter int SYNC_STAGES         = 2,
    parameter int DEBOUNCE_CYCLES     = 500000,
    parameter int RST_STRETCH_CYCLES  = 1024,
    parameter int RST_BTN_ACTIVE_HIGH = 1
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            btn_rst_i,
    input  logic [N_IN-1:0] raw_i,
    output logic [N_IN-1:0] db_o,
    output logic [N_IN-1:0] rise_o,
    output logic [N_IN-1:0] fall_o,
    output logic            db_valid_o,
    output logic            soc_rst_no
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam int VLD_TOTAL = SYNC_STAGES + DEBOUNCE_CYCLES;
    localparam int VLD_W = $clog2(VLD_TOTAL);
    localparam logic [VLD_W-1:0] VLD_LAST = VLD_W'(VLD_TOTAL - 1);

    localparam int STR_W = (RST_STRETCH_CYCLES > 1) ? $clog2(RST_STRETCH_CYCLES) : 1;
    localparam logic [STR_W-1:0] STR_LAST = STR_W'(RST_STRETCH_CYCLES - 1);

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_STRETCH = 2'd1,
        S_RUN     = 2'd2
    } rst_state_t;

    // The button is carried through the synchroniser as "released", so the
    // all-zero reset value of the chain reads as "pressed" for either
    // polarity and the post-reset stretch timing is the same for both.
    logic              w_btn_rel;
    logic [N_IN:0]     r_sync_p [SYNC_STAGES];
    logic [N_IN:0]     w_sync;
    logic [N_IN-1:0]   w_sync_raw;
    logic              w_btn_rel_s;

    logic [CNT_W-1:0]  r_cnt [N_IN];
    logic [N_IN-1:0]   r_db;
    logic [N_IN-1:0]   w_mis;
    logic [N_IN-1:0]   w_upd;

    logic [VLD_W-1:0]  r_vld_cnt;
    logic              r_db_valid;

    rst_state_t        r_state;
    rst_state_t        w_state_nxt;
    logic [STR_W-1:0]  r_str_cnt;
    logic [STR_W-1:0]  w_str_cnt_nxt;
    logic              r_soc_rst_n;

    assign w_btn_rel   = (RST_BTN_ACTIVE_HIGH != 0) ? ~btn_rst_i : btn_rst_i;
    assign w_sync      = r_sync_p[SYNC_STAGES-1];
    assign w_sync_raw  = w_sync[N_IN-1:0];
    assign w_btn_rel_s = w_sync[N_IN];

    // Synchroniser chain for all raw inputs plus the button.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                r_sync_p[s] <= '0;
            end
        end else begin
            r_sync_p[0] <= {w_btn_rel, raw_i};
            for (int s = 1; s < SYNC_STAGES; s++) begin
                r_sync_p[s] <= r_sync_p[s-1];
            end
        end
    end

    // A channel commits when it has disagreed with db_o for a full window.
    always_comb begin
        w_mis = w_sync_raw ^ r_db;
        w_upd = '0;
        for (int i = 0; i < N_IN; i++) begin
            w_upd[i] = w_mis[i] && (r_cnt[i] == DEB_LAST);
        end
    end

    // Per-channel debounce counters; any agreement restarts the window.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_IN; i++) begin
                r_cnt[i] <= '0;
            end
            r_db <= '0;
        end else begin
            for (int i = 0; i < N_IN; i++) begin
                if (!w_mis[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_upd[i]) begin
                    r_cnt[i] <= '0;
                    r_db[i]  <= w_sync_raw[i];
                end else begin
                    r_cnt[i] <= r_cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    assign db_o = r_db;

`ifdef BOARD_IO_EDGE_DETECT_EN
    logic [N_IN-1:0] r_rise;
    logic [N_IN-1:0] r_fall;

    // Edge pulses are registered alongside the db_o update so they line up
    // with the first cycle db_o shows the new level.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_rise <= '0;
            r_fall <= '0;
        end else begin
            r_rise <= w_upd & w_sync_raw;
            r_fall <= w_upd & ~w_sync_raw;
        end
    end

    assign rise_o = r_rise;
    assign fall_o = r_fall;
`else
    assign rise_o = '0;
    assign fall_o = '0;
`endif

    // One-shot window counter: db_valid_o sets once and holds until reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_vld_cnt  <= '0;
            r_db_valid <= 1'b0;
        end else if (!r_db_valid) begin
            if (r_vld_cnt == VLD_LAST) begin
                r_db_valid <= 1'b1;
            end else begin
                r_vld_cnt <= r_vld_cnt + VLD_W'(1);
            end
        end
    end

    assign db_valid_o = r_db_valid;

    // Reset FSM state, stretch counter and registered SoC reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= S_HOLD;
            r_str_cnt   <= '0;
            r_soc_rst_n <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_str_cnt   <= w_str_cnt_nxt;
            r_soc_rst_n <= (w_state_nxt == S_RUN);
        end
    end

    // Reset FSM next state: a visible press always returns to HOLD.
    always_comb begin
        w_state_nxt   = r_state;
        w_str_cnt_nxt = r_str_cnt;
        case (r_state)
            S_HOLD: begin
                w_str_cnt_nxt = '0;
                if (w_btn_rel_s) begin
                    w_state_nxt = S_STRETCH;
                end
            end
            S_STRETCH: begin
                if (!w_btn_rel_s) begin
                    w_state_nxt   = S_HOLD;
                    w_str_cnt_nxt = '0;
                end else if (r_str_cnt == STR_LAST) begin
                    w_state_nxt   = S_RUN;
                    w_str_cnt_nxt = '0;
                end else begin
                    w_str_cnt_nxt = r_str_cnt + STR_W'(1);
                end
            end
            S_RUN: begin
                w_str_cnt_nxt = '0;
                if (!w_btn_rel_s) begin
                    w_state_nxt = S_HOLD;
                end
            end
            default: begin
                w_state_nxt   = S_HOLD;
                w_str_cnt_nxt = '0;
            end
        endcase
    end

    assign soc_rst_no = r_soc_rst_n;

endmodule

// File: tb/tb_xilinx_board_io_cond.sv
// Scoreboard bench for xilinx_board_io_cond (N_IN=4, SYNC_STAGES=2,
// DEBOUNCE_CYCLES=8, RST_STRETCH_CYCLES=16). Expected output events are
// queued with the cycle they must appear in; a negedge monitor pops and
// compares every observed event. Adapts to BOARD_IO_EDGE_DETECT_EN.
module tb_xilinx_board_io_cond;

    localparam int N_IN = 4;
    localparam int SS   = 2;
    localparam int DEB  = 8;
    localparam int RS   = 16;
    localparam int DB_LAT  = SS + DEB;       // 10
    localparam int SOC_LAT = SS + 1 + RS;    // 19
`ifdef BOARD_IO_EDGE_DETECT_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    localparam int K_DB_UP  = 0;
    localparam int K_DB_DN  = 1;
    localparam int K_RISE   = 2;
    localparam int K_FALL   = 3;
    localparam int K_SOC_UP = 4;
    localparam int K_SOC_DN = 5;
    localparam int K_VALID  = 6;

    logic            clk_i     = 1'b0;
    logic            rst_ni    = 1'b0;
    logic            btn_rst_i = 1'b0;
    logic [N_IN-1:0] raw_i     = '0;
    logic [N_IN-1:0] db_o;
    logic [N_IN-1:0] rise_o;
    logic [N_IN-1:0] fall_o;
    logic            db_valid_o;
    logic            soc_rst_no;

    xilinx_board_io_cond #(
        .N_IN(N_IN), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DEB),
        .RST_STRETCH_CYCLES(RS), .RST_BTN_ACTIVE_HIGH(1)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .btn_rst_i(btn_rst_i), .raw_i(raw_i),
        .db_o(db_o), .rise_o(rise_o), .fall_o(fall_o),
        .db_valid_o(db_valid_o), .soc_rst_no(soc_rst_no)
    );

    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [15:0] code;
        logic [31:0] cyc;
    } ev_t;

    ev_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic ev_t mk(input int kind, input int ch, input int c);
        ev_t e;
        e.code = 16'(kind * 32 + ch);
        e.cyc  = 32'(c);
        return e;
    endfunction

    task automatic expect_ev(input int kind, input int ch, input int c);
        exp_q.push_back(mk(kind, ch, c));
    endtask

    task automatic note(input int kind, input int ch);
        ev_t obs;
        ev_t e;
        obs = mk(kind, ch, cyc);
        if (exp_q.size() == 0) begin
            chk($sformatf("unexpected_ev_k%0d_ch%0d", kind, ch), 64'(obs), '1);
        end else begin
            e = exp_q.pop_front();
            chk($sformatf("ev_k%0d_ch%0d", kind, ch), 64'(obs), 64'(e));
        end
    endtask

    logic [N_IN-1:0] p_db    = '0;
    logic            p_soc   = 1'b0;
    logic            p_valid = 1'b0;

    // Output-event monitor, sampled away from the active edge.
    always @(negedge clk_i) begin
        if (rst_ni) begin
            for (int ch = 0; ch < N_IN; ch++) begin
                if (db_o[ch] != p_db[ch]) note(db_o[ch] ? K_DB_UP : K_DB_DN, ch);
                if (rise_o[ch]) note(K_RISE, ch);
                if (fall_o[ch]) note(K_FALL, ch);
            end
            if (soc_rst_no != p_soc) note(soc_rst_no ? K_SOC_UP : K_SOC_DN, 0);
            if (db_valid_o != p_valid) note(K_VALID, db_valid_o ? 0 : 1);
        end
        p_db    = db_o;
        p_soc   = soc_rst_no;
        p_valid = db_valid_o;
    end

    task automatic negs(input int n);
        repeat (n) @(negedge clk_i);
    endtask

    task automatic drain(input string tag, input int limit);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < limit) begin
            @(negedge clk_i);
            k++;
        end
        chk({tag, "_pending"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        negs(12);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        int c1;

        // Reset values
        negs(5);
        chk("rst_db", 64'(db_o), 64'd0);
        chk("rst_rise", 64'(rise_o), 64'd0);
        chk("rst_fall", 64'(fall_o), 64'd0);
        chk("rst_valid", 64'(db_valid_o), 64'd0);
        chk("rst_soc", 64'(soc_rst_no), 64'd0);

        // Reset release with the button idle
        c0 = cyc;
        rst_ni = 1'b1;
        expect_ev(K_VALID, 0, c0 + DB_LAT);
        expect_ev(K_SOC_UP, 0, c0 + SOC_LAT);
        drain("rst_release", 40);
        chk("release_db", 64'(db_o), 64'd0);

        // Clean rising and falling edge on channel 2
        c0 = cyc;
        raw_i[2] = 1'b1;
        expect_ev(K_DB_UP, 2, c0 + DB_LAT);
        if (EDGE_EN) expect_ev(K_RISE, 2, c0 + DB_LAT);
        drain("clean_rise", 40);
        chk("clean_db_hi", 64'(db_o), 64'h4);
        chk("clean_rise_idle", 64'(rise_o), 64'd0);

        c0 = cyc;
        raw_i[2] = 1'b0;
        expect_ev(K_DB_DN, 2, c0 + DB_LAT);
        if (EDGE_EN) expect_ev(K_FALL, 2, c0 + DB_LAT);
        drain("clean_fall", 40);
        chk("clean_db_lo", 64'(db_o), 64'd0);

        // Bounce rejection on channel 1: 10 toggles, 7 cycles apart
        for (int t = 0; t < 10; t++) begin
            raw_i[1] = ~raw_i[1];
            negs(7);
        end
        chk("bounce_db_low", 64'(db_o[1]), 64'd0);
        c0 = cyc;
        raw_i[1] = 1'b1;
        expect_ev(K_DB_UP, 1, c0 + DB_LAT);
        if (EDGE_EN) expect_ev(K_RISE, 1, c0 + DB_LAT);
        drain("bounce_settle", 40);
        chk("bounce_db_hi", 64'(db_o), 64'h2);

        // Re-press during STRETCH restarts the full stretch
        c0 = cyc;
        btn_rst_i = 1'b1;
        expect_ev(K_SOC_DN, 0, c0 + SS + 1);
        negs(3);
        btn_rst_i = 1'b0;
        negs(13);
        btn_rst_i = 1'b1;
        negs(3);
        btn_rst_i = 1'b0;
        c1 = cyc;
        expect_ev(K_SOC_UP, 0, c1 + SOC_LAT);
        drain("repress", 60);
        chk("repress_soc", 64'(soc_rst_no), 64'd1);

        // Async reset while channel 0 counter is at 5
        raw_i[0] = 1'b1;
        negs(7);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_db", 64'(db_o), 64'd0);
        chk("arst_rise", 64'(rise_o), 64'd0);
        chk("arst_fall", 64'(fall_o), 64'd0);
        chk("arst_valid", 64'(db_valid_o), 64'd0);
        chk("arst_soc", 64'(soc_rst_no), 64'd0);
        negs(3);
        c0 = cyc;
        rst_ni = 1'b1;
        expect_ev(K_DB_UP, 0, c0 + DB_LAT);
        if (EDGE_EN) expect_ev(K_RISE, 0, c0 + DB_LAT);
        expect_ev(K_DB_UP, 1, c0 + DB_LAT);
        if (EDGE_EN) expect_ev(K_RISE, 1, c0 + DB_LAT);
        expect_ev(K_VALID, 0, c0 + DB_LAT);
        expect_ev(K_SOC_UP, 0, c0 + SOC_LAT);
        drain("arst_recover", 40);
        chk("arst_db_final", 64'(db_o), 64'h3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
